// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word in over a
// valid/ready load port, one bit per accepted beat out, with a last flag.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] D,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic in_shift;
    logic at_last;
    logic beat;
    logic load;

    assign in_shift = (state_q == SHIFT);
    assign at_last  = (cnt_q == '0);
    assign beat     = in_shift && sout_ready;

    // Ready never looks at load_valid, so no loop with the upstream.
    assign load_ready = !rst && (!in_shift || (at_last && sout_ready));
    assign load       = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            sreg_d  = D;
            cnt_d   = CNT_TOP;
            state_d = SHIFT;
        end else if (beat && at_last) begin
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (beat) begin
            sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
            cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sout       = in_shift &&
                        (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);
    assign sout_valid = in_shift;
    assign sout_last  = in_shift && at_last;
    assign busy       = in_shift;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed vector bench for piso_serializer: MSB-first, LSB-first and
// WIDTH=1 instances driven from per-cycle tables plus a reset sequence.
module tb_piso_serializer;

    typedef struct {
        logic       lv;
        logic [3:0] d;
        logic       rdy;
        logic       e_sout;
        logic       e_sv;
        logic       e_last;
        logic       e_busy;
        logic       e_lr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_lv = 0, a_rdy = 0;
    logic [3:0] a_d = '0;
    logic       a_lr, a_sout, a_sv, a_last, a_busy;

    logic       b_lv = 0, b_rdy = 0;
    logic [3:0] b_d = '0;
    logic       b_lr, b_sout, b_sv, b_last, b_busy;

    logic       c_lv = 0, c_rdy = 0;
    logic [0:0] c_d = '0;
    logic       c_lr, c_sout, c_sv, c_last, c_busy;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .load_valid(a_lv), .load_ready(a_lr), .D(a_d),
        .sout(a_sout), .sout_valid(a_sv), .sout_ready(a_rdy),
        .sout_last(a_last), .busy(a_busy)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .load_valid(b_lv), .load_ready(b_lr), .D(b_d),
        .sout(b_sout), .sout_valid(b_sv), .sout_ready(b_rdy),
        .sout_last(b_last), .busy(b_busy)
    );

    piso_serializer #(.WIDTH(1), .LSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst),
        .load_valid(c_lv), .load_ready(c_lr), .D(c_d),
        .sout(c_sout), .sout_valid(c_sv), .sout_ready(c_rdy),
        .sout_last(c_last), .busy(c_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int idx,
                       input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input int dut, input vec_t v);
        case (dut)
            0: begin a_lv = v.lv; a_d = v.d; a_rdy = v.rdy; end
            1: begin b_lv = v.lv; b_d = v.d; b_rdy = v.rdy; end
            default: begin c_lv = v.lv; c_d = v.d[0:0]; c_rdy = v.rdy; end
        endcase
    endtask

    task automatic sample(input int dut, input int idx, input vec_t v);
        logic so, sv, sl, bz, lr;
        case (dut)
            0: begin so = a_sout; sv = a_sv; sl = a_last; bz = a_busy; lr = a_lr; end
            1: begin so = b_sout; sv = b_sv; sl = b_last; bz = b_busy; lr = b_lr; end
            default: begin so = c_sout; sv = c_sv; sl = c_last; bz = c_busy; lr = c_lr; end
        endcase
        chk($sformatf("d%0d.sout", dut), idx, so, v.e_sout);
        chk($sformatf("d%0d.sout_valid", dut), idx, sv, v.e_sv);
        chk($sformatf("d%0d.sout_last", dut), idx, sl, v.e_last);
        chk($sformatf("d%0d.busy", dut), idx, bz, v.e_busy);
        chk($sformatf("d%0d.load_ready", dut), idx, lr, v.e_lr);
    endtask

    // One clock cycle: drive after the edge, check mid-cycle.
    task automatic step(input int dut, input int idx, input vec_t v);
        @(posedge clk);
        #1;
        drive(dut, v);
        @(negedge clk);
        sample(dut, idx, v);
    endtask

    function automatic vec_t mk(input logic lv, input logic [3:0] d,
                                input logic rdy, input logic so,
                                input logic sv, input logic sl,
                                input logic bz, input logic lr);
        vec_t v;
        v.lv = lv; v.d = d; v.rdy = rdy;
        v.e_sout = so; v.e_sv = sv; v.e_last = sl;
        v.e_busy = bz; v.e_lr = lr;
        return v;
    endfunction

    vec_t va[$];
    vec_t vb[$];
    vec_t vc[$];
    vec_t vr[$];
    vec_t idle_v;

    initial begin
        // MSB-first basic: 1011 -> 1,0,1,1
        va.push_back(mk(1, 4'hB, 1, 0, 0, 0, 0, 1));
        va.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 1, 1, 1, 1, 1));
        va.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 1));
        // Backpressure: 1001, stall on cycles 2-3, D noise ignored
        va.push_back(mk(1, 4'h9, 1, 0, 0, 0, 0, 1));
        va.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 0));
        va.push_back(mk(1, 4'h6, 0, 0, 1, 0, 1, 0));
        va.push_back(mk(1, 4'hF, 0, 0, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 1, 1, 1, 1, 1));
        // Back-to-back: A then 5 -> 1010 0101, no gap
        va.push_back(mk(1, 4'hA, 1, 0, 0, 0, 0, 1));
        va.push_back(mk(1, 4'h5, 1, 1, 1, 0, 1, 0));
        va.push_back(mk(1, 4'h5, 1, 0, 1, 0, 1, 0));
        va.push_back(mk(1, 4'h5, 1, 1, 1, 0, 1, 0));
        va.push_back(mk(1, 4'h5, 1, 0, 1, 1, 1, 1));
        va.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 0));
        va.push_back(mk(0, 4'h0, 1, 1, 1, 1, 1, 1));
        va.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 1));

        // LSB-first: 1011 -> 1,1,0,1
        vb.push_back(mk(1, 4'hB, 1, 0, 0, 0, 0, 1));
        vb.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 0));
        vb.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 0));
        vb.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 0));
        vb.push_back(mk(0, 4'h0, 1, 1, 1, 1, 1, 1));
        vb.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 1));

        // WIDTH=1: words 1,0,1 streamed
        vc.push_back(mk(1, 4'h1, 1, 0, 0, 0, 0, 1));
        vc.push_back(mk(1, 4'h0, 1, 1, 1, 1, 1, 1));
        vc.push_back(mk(1, 4'h1, 1, 0, 1, 1, 1, 1));
        vc.push_back(mk(0, 4'h0, 1, 1, 1, 1, 1, 1));
        vc.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 1));

        // After mid-word reset: fresh 0011 -> 0,0,1,1
        vr.push_back(mk(1, 4'h3, 1, 0, 0, 0, 0, 1));
        vr.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 0));
        vr.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 0));
        vr.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 0));
        vr.push_back(mk(0, 4'h0, 1, 1, 1, 1, 1, 1));
        vr.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 1));

        idle_v = mk(0, 4'h0, 0, 0, 0, 0, 0, 0);

        // Reset state, with load_valid high to show it is refused
        a_lv = 1'b1; a_d = 4'hF; a_rdy = 1'b1;
        repeat (2) @(negedge clk);
        sample(0, 900, idle_v);
        sample(1, 900, idle_v);
        sample(2, 900, idle_v);
        a_lv = 1'b0;
        rst = 1'b0;

        foreach (va[i]) step(0, i, va[i]);
        foreach (vb[i]) step(1, i, vb[i]);
        foreach (vc[i]) step(2, i, vc[i]);

        // Async reset during bit 2 of 4'hF
        step(0, 100, mk(1, 4'hF, 1, 0, 0, 0, 0, 1));
        step(0, 101, mk(0, 4'h0, 1, 1, 1, 0, 1, 0));
        @(posedge clk);
        #1;
        drive(0, mk(0, 4'h0, 1, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst.sout_valid", 102, a_sv, 1'b1);
        chk("pre_rst.sout", 102, a_sout, 1'b1);
        rst = 1'b1;
        #1;
        sample(0, 103, idle_v);
        @(negedge clk);
        @(negedge clk);
        sample(0, 104, idle_v);
        rst = 1'b0;
        #1;
        chk("post_rst.load_ready", 105, a_lr, 1'b1);

        foreach (vr[i]) step(0, 200 + i, vr[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
